// File: rtl/pow_n_pkg.sv
// pow_n_pkg: shared definitions for the iterative power engine.
//   - pow_state_e : FSM state encoding (IDLE / CALC / DONE)
//   - DEF_WIDTH   : default operand/result width
//   - DEF_EXP_W   : default exponent width
//   - prod_w()    : full product width (2*WIDTH) for a WIDTH x WIDTH multiply
package pow_n_pkg;

  localparam int DEF_WIDTH = 18;
  localparam int DEF_EXP_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } pow_state_e;

  // Width of the untruncated product of two w-bit operands.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/pow_n_mul_wrap.sv
// pow_n_mul_wrap: combinational WIDTH x WIDTH unsigned multiply.
// Produces the low WIDTH bits of the full product and a flag that is set
// when any bit of the upper half is nonzero (i.e. the product did not fit).
// Ports:
//   a_i, b_i  : operands
//   lo_o      : product mod 2^WIDTH
//   hi_nz_o   : 1 iff product >= 2^WIDTH
module pow_n_mul_wrap
  import pow_n_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] lo_o,
  output logic             hi_nz_o
);

  localparam int PW = prod_w(WIDTH);

  logic [PW-1:0] prod;

  // Zero-extend both operands so the multiply is evaluated at full width.
  assign prod    = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
  assign lo_o    = prod[WIDTH-1:0];
  assign hi_nz_o = |prod[PW-1:WIDTH];

endmodule

// File: rtl/pow_n_iterative.sv
// pow_n_iterative: shared multi-cycle engine computing n^exp mod 2^WIDTH
// with an exact overflow flag, using LSB-first square-and-multiply.
// Ports:
//   clock    : clock, all state changes on the rising edge
//   reset    : synchronous active-high reset, overrides everything
//   run      : start request, honoured in IDLE or DONE only
//   n, exp   : base and exponent, captured on the accepted run edge
//   busy     : high while iterating (CALC)
//   ready    : one-cycle pulse, result/overflow valid from this cycle
//   result   : n^exp mod 2^WIDTH, held until the next completion
//   overflow : 1 iff the true n^exp >= 2^WIDTH
module pow_n_iterative
  import pow_n_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXP_W = DEF_EXP_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] n,
  input  logic [EXP_W-1:0] exp,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  pow_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic             ovf_q, ovf_d;
  // Sticky: the true value of base_q no longer fits in WIDTH bits.
  logic             base_ovf_q, base_ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] ab_lo, bb_lo;
  logic             ab_ovf, bb_ovf;
  logic [EXP_W-1:0] e_shr;

  pow_n_mul_wrap #(.WIDTH(WIDTH)) u_mul_acc (
    .a_i     (acc_q),
    .b_i     (base_q),
    .lo_o    (ab_lo),
    .hi_nz_o (ab_ovf)
  );

  pow_n_mul_wrap #(.WIDTH(WIDTH)) u_mul_sq (
    .a_i     (base_q),
    .b_i     (base_q),
    .lo_o    (bb_lo),
    .hi_nz_o (bb_ovf)
  );

  assign e_shr = e_q >> 1;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    base_d     = base_q;
    e_d        = e_q;
    ovf_d      = ovf_q;
    base_ovf_d = base_ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (run) begin
          acc_d      = ONE;
          base_d     = n;
          e_d        = exp;
          ovf_d      = 1'b0;
          base_ovf_d = 1'b0;
          if (exp == '0) begin
            // x^0 = 1 and can never overflow; finish without iterating.
            state_d    = DONE;
            result_d   = ONE;
            overflow_d = 1'b0;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        if (e_q[0]) begin
          acc_d = ab_lo;
          // A base that already overflowed makes any product with it overflow.
          ovf_d = ovf_q | ab_ovf | base_ovf_q;
        end
        base_d = bb_lo;
        // Only a squared base that will still be multiplied in can matter.
        if (e_shr != '0) base_ovf_d = base_ovf_q | bb_ovf;
        e_d = e_shr;
        if (e_shr == '0) begin
          // Capture the final accumulator on entry to DONE so it is
          // visible in the same cycle as ready.
          state_d    = DONE;
          result_d   = acc_d;
          overflow_d = ovf_d;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      base_q     <= '0;
      e_q        <= '0;
      ovf_q      <= 1'b0;
      base_ovf_q <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      base_q     <= base_d;
      e_q        <= e_d;
      ovf_q      <= ovf_d;
      base_ovf_q <= base_ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == CALC);
  assign ready    = (state_q == DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pow_n_iterative.sv
module tb_pow_n_iterative;

  localparam int W  = 18;
  localparam int EW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [W-1:0]  n_in;
  logic [EW-1:0] exp_in;
  logic          busy, ready, overflow;
  logic [W-1:0]  result;

  pow_n_iterative #(.WIDTH(W), .EXP_W(EW)) dut (
    .clock    (clk),
    .reset    (rst),
    .run      (run),
    .n        (n_in),
    .exp      (exp_in),
    .busy     (busy),
    .ready    (ready),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  n;
    logic [EW-1:0] e;
    logic [W-1:0]  res;
    logic          ovf;
    int            lat;   // bit-length of exponent
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ready_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Scoreboard: every ready pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    if (!rst && ready) begin
      ready_seen++;
      if (sb.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("result", 64'(result), 64'(x.res));
        check("overflow", 64'(overflow), 64'(x.ovf));
        check("busy_at_ready", 64'(busy), 64'd0);
      end
    end
  end

  // Called at a negedge; drives run for one edge and books the expectation.
  task automatic start(input logic [W-1:0] nv, input logic [EW-1:0] ev,
                       input logic [W-1:0] res, input logic ovf);
    exp_t x;
    run = 1'b1; n_in = nv; exp_in = ev;
    x.res = res; x.ovf = ovf;
    sb.push_back(x);
    @(negedge clk);
    run = 1'b0;
  endtask

  // Waits for ready; cycles counts negedges since the run edge.
  task automatic wait_ready(input string name, input int lat, input int elapsed);
    int  cycles;
    logic bsy_ok;
    cycles = elapsed;
    bsy_ok = 1'b1;
    while (!ready && cycles < 64) begin
      if (!busy) bsy_ok = 1'b0;
      @(negedge clk);
      cycles++;
    end
    check({name, "_ready_seen"}, 64'(ready), 64'd1);
    check({name, "_latency"}, 64'(cycles), 64'(lat + 1));
    check({name, "_busy_in_calc"}, 64'(bsy_ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen0;
    vecs[0]  = '{n: 18'd3,      e: 5'd5,  res: 18'd243,    ovf: 1'b0, lat: 3};
    vecs[1]  = '{n: 18'd12345,  e: 5'd0,  res: 18'd1,      ovf: 1'b0, lat: 0};
    vecs[2]  = '{n: 18'd100,    e: 5'd3,  res: 18'd213568, ovf: 1'b1, lat: 2};
    vecs[3]  = '{n: 18'd512,    e: 5'd2,  res: 18'd0,      ovf: 1'b1, lat: 2};
    vecs[4]  = '{n: 18'd1000,   e: 5'd1,  res: 18'd1000,   ovf: 1'b0, lat: 1};
    vecs[5]  = '{n: 18'd0,      e: 5'd0,  res: 18'd1,      ovf: 1'b0, lat: 0};
    vecs[6]  = '{n: 18'd0,      e: 5'd7,  res: 18'd0,      ovf: 1'b0, lat: 3};
    vecs[7]  = '{n: 18'd1,      e: 5'd31, res: 18'd1,      ovf: 1'b0, lat: 5};
    vecs[8]  = '{n: 18'd2,      e: 5'd17, res: 18'd131072, ovf: 1'b0, lat: 5};
    vecs[9]  = '{n: 18'd2,      e: 5'd18, res: 18'd0,      ovf: 1'b1, lat: 5};
    vecs[10] = '{n: 18'd7,      e: 5'd6,  res: 18'd117649, ovf: 1'b0, lat: 3};
    vecs[11] = '{n: 18'd262143, e: 5'd2,  res: 18'd1,      ovf: 1'b1, lat: 2};

    rst = 1'b1; run = 1'b0; n_in = '0; exp_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      start(vecs[i].n, vecs[i].e, vecs[i].res, vecs[i].ovf);
      wait_ready($sformatf("vec%0d", i), vecs[i].lat, 1);
      @(negedge clk);
      check($sformatf("vec%0d_hold", i), 64'(result), 64'(vecs[i].res));
    end

    // Long job with a run pulse mid-CALC that must be ignored.
    start(18'd2, 5'd31, 18'd0, 1'b1);
    run = 1'b1; n_in = 18'd5; exp_in = 5'd2;
    @(negedge clk);
    run = 1'b0;
    wait_ready("ignored_run", 5, 2);

    // Back-to-back: new run issued in the DONE cycle.
    start(18'd5, 5'd2, 18'd25, 1'b0);
    wait_ready("back_to_back", 2, 1);
    @(negedge clk);

    // Reset mid-CALC: outputs clear and the aborted job never completes.
    start(18'd2, 5'd31, 18'd0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    seen0 = ready_seen;
    repeat (10) @(negedge clk);
    check("midrst_no_ready", 64'(ready_seen - seen0), 64'd0);

    // Recovery after reset.
    start(18'd3, 5'd5, 18'd243, 1'b0);
    wait_ready("after_reset", 3, 1);
    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pow_n_iterative.md
Name: pow_n_iterative

Overview:
- Parametrised successor to the fixed pow-5 units: computes n^exp for a runtime exponent using an LSB-first square-and-multiply FSM.
- Result is WIDTH bits, wrap-around (modulo 2^WIDTH), plus an exact overflow flag.
- Uses a run/ready handshake with a busy indication.
- Sits beside the existing arithmetic blocks as a shared multi-cycle power engine, so pipelines are not duplicated per exponent.

Parameters:
- WIDTH, 18, operand/result width in bits.
- EXP_W, 5, exponent width in bits; max exponent 2^EXP_W-1.

Ports:
- clock    input   1        single clock; all state changes on rising edge.
- reset    input   1        synchronous, active-high reset.
- run      input   1        start request; sampled on a clock edge, honoured only when not busy.
- n        input   WIDTH    base (unsigned); captured on the accepted run edge.
- exp      input   EXP_W    exponent (unsigned); captured on the accepted run edge.
- busy     output  1        high while in CALC; run is ignored.
- ready    output  1        one-cycle pulse when result/overflow become valid.
- result   output  WIDTH    n^exp mod 2^WIDTH; held from the ready pulse until the next accepted run.
- overflow output  1        1 iff the true n^exp >= 2^WIDTH; held with result.

Behaviour:
- Reset, synchronous and active-high, takes priority over everything, including mid-operation:
  - state=IDLE; busy=0, ready=0, result=0, overflow=0; internal regs cleared.
- States: IDLE, CALC, DONE. busy = (state==CALC); ready = (state==DONE).
- Accept rule: run=1 in IDLE or DONE on edge E0 loads acc=1, base=n, e=exp, ovf=0, base_ovf=0.
  - Next state is CALC if exp!=0, else DONE.
- run=1 in CALC is ignored; the operation in flight is unaffected.
- CALC, per edge, all updates from pre-edge values:
  - if e[0]: acc <= low WIDTH bits of acc*base; ovf |= hi_nonzero(acc*base) | base_ovf.
  - base <= low(base*base); if (e>>1)!=0: base_ovf |= hi_nonzero(base*base).
  - e <= e>>1; when (e>>1)==0 go to DONE.
  - Squaring overflow that is never used must not set overflow.
- DONE lasts exactly one cycle:
  - result<=acc and overflow<=ovf are registered on entry to DONE, so they are valid in the same cycle ready=1.
  - Next state is IDLE, or a new load if run=1.
- Latency: let k = bit-length of exp (k=0 for exp=0). ready is high in the cycle after edge E(max(k,0)) counted from E0.
  - So the run edge itself is E0; exp=0 gives ready right after E0; exp=5 (k=3) gives ready after E3.
- Throughput: back-to-back run is allowed in the DONE cycle; no idle gap is required.
- n=0: result 0 for exp>0, 1 for exp=0; overflow=0.
- n=1: result 1 for every exp; overflow=0.
- Multiplies are full 2*WIDTH products, split into the low word and a nonzero-high flag.

Decomposition:
- Shared package pow_n_pkg: state encoding constants (IDLE/CALC/DONE), default WIDTH/EXP_W, and a helper constant for product width 2*WIDTH.
- One sub-module, pow_n_mul_wrap: combinational WIDTH x WIDTH multiply producing low[WIDTH] and ovf (high half nonzero).
  - Instantiated twice: one for acc*base, one for base*base.
- The FSM, registers and output hold logic live in the top.

Test Plan:
- WIDTH=18: n=3, exp=5 -> ready high exactly 3 edges after the run edge; result=243, overflow=0; busy=1 for cycles 1-3.
- n=12345, exp=0 -> ready in the cycle after the run edge; result=1, overflow=0; busy never asserted.
- n=100, exp=3 -> result=213568 (1000000 mod 2^18), overflow=1.
- n=512, exp=2 -> result=0, overflow=1.
- n=1000, exp=1 -> result=1000, overflow=0 (the unused base squaring overflow is not flagged).
- run with n=2, exp=31 and then:
  - pulse run (n=5, exp=2) mid-CALC -> ignored; result=0, overflow=1 for the first job.
  - issue the second run in the DONE cycle -> result 25 follows 2 edges later.
  - assert reset mid-CALC -> next cycle busy=0, ready=0, result=0, overflow=0, and no ready pulse afterwards.
